// File: rtl/sram_arbiter.sv
// Two-master (instruction / data) to one-slave arbiter for the SRAM-like bus.
// One transaction in flight; data has priority, with a starvation guard for instruction fetch.
module sram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_owner;
  logic [3:0]  r_starve_cnt;

  logic        r_wr;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_sel_data;
  logic        w_grant_data;
  logic        w_accept;
  logic        w_resp;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= LIMIT) ? LIMIT : v + 4'd1;
  endfunction

  // Inst wins a tie only once data has taken LIMIT grants in a row past a waiting inst.
  assign w_sel_data = data_req && !(inst_req && (r_starve_cnt == LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && mem_req)
        r_owner <= w_grant_data;
      if (w_accept)
        r_starve_cnt <= (w_grant_data && inst_req) ? sat_inc(r_starve_cnt) : 4'd0;
    end
  end

  // Request fields are frozen while the slave stalls addr_ok.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && mem_req && !mem_addr_ok) begin
      r_wr    <= mem_wr;
      r_size  <= mem_size;
      r_wstrb <= mem_wstrb;
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (mem_req) w_next_state = mem_addr_ok ? ST_WAIT : ST_REQ;
      ST_REQ:  if (mem_addr_ok) w_next_state = ST_WAIT;
      ST_WAIT: if (mem_data_ok) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    w_grant_data = r_owner;
    mem_wr       = r_wr;
    mem_size     = r_size;
    mem_wstrb    = r_wstrb;
    mem_addr     = r_addr;
    mem_wdata    = r_wdata;
    case (r_state)
      ST_IDLE: begin
        w_grant_data = w_sel_data;
        mem_req      = data_req || inst_req;
        if (w_sel_data) begin
          mem_wr    = data_wr;
          mem_size  = data_size;
          mem_wstrb = data_wstrb;
          mem_addr  = data_addr;
          mem_wdata = data_wdata;
        end else begin
          mem_wr    = inst_wr;
          mem_size  = inst_size;
          mem_wstrb = inst_wstrb;
          mem_addr  = inst_addr;
          mem_wdata = inst_wdata;
        end
      end
      ST_REQ:  mem_req = 1'b1;
      default: mem_req = 1'b0;
    endcase
    if (reset)
      mem_req = 1'b0;
    w_accept     = mem_req && mem_addr_ok;
    inst_addr_ok = w_accept && !w_grant_data;
    data_addr_ok = w_accept && w_grant_data;
    w_resp       = (r_state == ST_WAIT) && mem_data_ok && !reset;
    inst_data_ok = w_resp && !r_owner;
    data_data_ok = w_resp && r_owner;
  end

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule
